// File: rtl/alias_bus_arbiter_if.sv
// alias_bus_arbiter_if
//   Bundles the request side and the resolved-bus side of the shared-bus
//   arbiter so the channels and the arbiter connect through one port.
//
//   Signals
//     req        NCH            per-channel drive request
//     wdata      NCH*WIDTH      per-channel drive data, channel i at [i*WIDTH +: WIDTH]
//     grant      NCH            one-hot current owner, all-zero when idle
//     owner      $clog2(NCH)    index of the current owner, 0 when idle
//     bus        WIDTH          resolved shared value
//     bus_valid  1              bus was written by an owner on the previous edge
//     contend    16             saturating count of contended cycles
//
//   Modports
//     master     channel side: drives req/wdata, observes the results
//     slave      arbiter side: consumes req/wdata, drives the results
interface alias_bus_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 3
);
  localparam int OW = $clog2(NCH);

  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] wdata;
  logic [NCH-1:0]       grant;
  logic [OW-1:0]        owner;
  logic [WIDTH-1:0]     bus;
  logic                 bus_valid;
  logic [15:0]          contend;

  modport master (
    output req, wdata,
    input  grant, owner, bus, bus_valid, contend
  );

  modport slave (
    input  req, wdata,
    output grant, owner, bus, bus_valid, contend
  );
endinterface

// File: rtl/alias_bus_arbiter.sv
// alias_bus_arbiter
//   N-channel shared-bus resolver. Channels request the single shared net;
//   a round-robin arbiter with a bounded hold picks exactly one owner per
//   cycle and the owner's data is registered onto the bus every channel
//   reads, so all channels always observe one consistent value. Also keeps
//   a saturating count of cycles in which more than one channel requested.
//
//   Ports
//     clk   in   clock, all state updates on the rising edge
//     rst   in   synchronous reset, active-high, wins over everything else
//     ab    slave modport of alias_bus_arbiter_if (req, wdata in;
//           grant, owner, bus, bus_valid, contend out)
module alias_bus_arbiter #(
  parameter int               WIDTH     = 32,
  parameter int               NCH       = 3,
  parameter int               HOLD_MAX  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'hdeadbeef)
) (
  input  logic                clk,
  input  logic                rst,
  alias_bus_arbiter_if.slave  ab
);
  localparam int OW = $clog2(NCH);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q, state_next;
  logic [OW-1:0]    owner_q, owner_next;
  logic [OW-1:0]    rr_q, rr_next;
  logic [HW-1:0]    hold_q, hold_next;
  logic [WIDTH-1:0] bus_q;
  logic             bus_valid_q;
  logic [15:0]      contend_q;
  logic [NCH-1:0]   others;
  logic             multi_req;

  // First requester found scanning upward from start, wrapping NCH-1 -> 0.
  function automatic logic [OW-1:0] pick_from(input logic [NCH-1:0] r,
                                               input logic [OW-1:0]  start);
    logic [OW-1:0] result;
    logic [OW-1:0] idx;
    logic          found;
    result = '0;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = OW'((int'(start) + i) % NCH);
      if (!found && r[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  function automatic logic [OW-1:0] next_of(input logic [OW-1:0] o);
    return OW'((int'(o) + 1) % NCH);
  endfunction

  // Requests from everyone except the current owner decide whether a
  // handover or a forced rotation is possible.
  assign others    = ab.req & ~(NCH'(1) << owner_q);
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = |(ab.req & (ab.req - 1'b1));

  // State register plus the registered bus and contention counter. The bus
  // captures the owner held before the edge, so it lags grant by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      bus_q       <= RESET_VAL;
      bus_valid_q <= 1'b0;
      contend_q   <= '0;
    end else begin
      state_q <= state_next;
      owner_q <= owner_next;
      rr_q    <= rr_next;
      hold_q  <= hold_next;
      if (state_q == OWNED) begin
        bus_q       <= ab.wdata[owner_q*WIDTH +: WIDTH];
        bus_valid_q <= 1'b1;
      end else begin
        bus_valid_q <= 1'b0;
      end
      if (multi_req && contend_q != 16'hffff) begin
        contend_q <= contend_q + 16'd1;
      end
    end
  end

  // Next-state: idle pickup from the rr pointer, release with same-edge
  // handover, hold counting, and forced rotation once the hold limit is hit.
  always_comb begin
    state_next = state_q;
    owner_next = owner_q;
    rr_next    = rr_q;
    hold_next  = hold_q;
    case (state_q)
      IDLE: begin
        if (|ab.req) begin
          state_next = OWNED;
          owner_next = pick_from(ab.req, rr_q);
          hold_next  = HW'(1);
        end
      end
      OWNED: begin
        if (!ab.req[owner_q]) begin
          rr_next = next_of(owner_q);
          if (|others) begin
            owner_next = pick_from(others, next_of(owner_q));
            hold_next  = HW'(1);
          end else begin
            state_next = IDLE;
            owner_next = '0;
            hold_next  = '0;
          end
        end else if (!(|others)) begin
          if (hold_q != HW'(HOLD_MAX)) begin
            hold_next = hold_q + 1'b1;
          end
        end else if (hold_q != HW'(HOLD_MAX)) begin
          hold_next = hold_q + 1'b1;
        end else begin
          rr_next    = next_of(owner_q);
          owner_next = pick_from(others, next_of(owner_q));
          hold_next  = HW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = '0;
        hold_next  = '0;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so grant/owner change
  // only on clock edges.
  always_comb begin
    ab.grant = '0;
    ab.owner = '0;
    if (state_q == OWNED) begin
      ab.grant = NCH'(1) << owner_q;
      ab.owner = owner_q;
    end
  end

  assign ab.bus       = bus_q;
  assign ab.bus_valid = bus_valid_q;
  assign ab.contend   = contend_q;
endmodule
